seq_magnitude_comparator: RTL

Parametrised, multi-cycle magnitude and equality comparator for the Booth multiplier datapath. It replaces fixed 8-bit equality checking with a WIDTH-bit compare that reports eq, gt and lt in unsigned or two's-complement mode. It scans DIGIT bits per cycle from the MSB and terminates early on the first differing chunk. It uses a valid/ready handshake on input and output and keeps a saturating count of equal results. Typical uses are operand checks and result verification next to the multiplier core.

---
 rtl/seq_magnitude_comparator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude/equality comparator, scanning DIGIT bits per
// cycle from the MSB with early exit, valid/ready on both sides and a match counter.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    input  logic             clr_count,
    output logic [15:0]      match_count
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic              eq_reg, eq_next;
    logic              gt_reg, gt_next;
    logic              lt_reg, lt_next;
    logic              out_valid_reg, out_valid_next;
    logic [15:0]       count_reg, count_next;

    logic [DIGIT-1:0]  a_chunk [NCHUNK];
    logic [DIGIT-1:0]  b_chunk [NCHUNK];
    logic [DIGIT-1:0]  a_cur, b_cur;
    logic [WIDTH-1:0]  sign_flip;
    logic              accept, out_hs;

    // Chunk 0 is the most significant DIGIT bits.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[WIDTH-1-gi*DIGIT -: DIGIT];
            assign b_chunk[gi] = b_reg[WIDTH-1-gi*DIGIT -: DIGIT];
        end
    endgenerate

    assign a_cur = a_chunk[idx_reg];
    assign b_cur = b_chunk[idx_reg];

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    assign sign_flip = WIDTH'(signed_mode) << (WIDTH - 1);

    assign in_ready = rst_n && (state_reg == IDLE);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_reg && out_ready;

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        idx_next       = idx_reg;
        eq_next        = eq_reg;
        gt_next        = gt_reg;
        lt_next        = lt_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    a_next     = a ^ sign_flip;
                    b_next     = b ^ sign_flip;
                    idx_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (a_cur != b_cur) begin
                    gt_next        = (a_cur > b_cur);
                    lt_next        = (a_cur < b_cur);
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end else if (idx_reg == LAST_IDX) begin
                    eq_next        = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_hs) begin
                    eq_next        = 1'b0;
                    gt_next        = 1'b0;
                    lt_next        = 1'b0;
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (clr_count) begin
            count_next = '0;
        end else if (out_hs && eq_reg && (count_reg != 16'hFFFF)) begin
            count_next = count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            idx_reg       <= '0;
            eq_reg        <= 1'b0;
            gt_reg        <= 1'b0;
            lt_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            idx_reg       <= idx_next;
            eq_reg        <= eq_next;
            gt_reg        <= gt_next;
            lt_reg        <= lt_next;
            out_valid_reg <= out_valid_next;
            count_reg     <= count_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign eq          = eq_reg;
    assign gt          = gt_reg;
    assign lt          = lt_reg;
    assign match_count = count_reg;

endmodule
